wb_slave_mem: RTL and testbench

Synchronous Wishbone slave memory model that terminates the cycles produced by the testbench Wishbone master. It supplies a 16-word × 32-bit register store with byte-lane writes, programmable wait states, out-of-range error termination and periodic retry injection. It exercises the master's single, block and read-modify-write paths without the GPIO core in the loop.

---
 rtl/wb_slave_mem.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_slave_mem.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem.sv
// Wishbone slave memory model: 16 x 32-bit store with byte lanes, fixed wait
// states, out-of-range error termination and periodic retry injection.
module wb_slave_mem #(
  parameter int unsigned aw        = 8,
  parameter int unsigned WAIT      = 1,
  parameter int unsigned RTY_EVERY = 0
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [aw-1:0] ADR_I,
  input  logic [3:0]    SEL_I,
  input  logic [31:0]   DAT_I,
  input  logic [3:0]    TAG_I,
  output logic [31:0]   DAT_O,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          RTY_O,
  output logic [3:0]    TAG_O
);

  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned TW    = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned IW    = 4;
  localparam int unsigned WORDS = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT);
  localparam logic [CW-1:0] RTY_N   = CW'(RTY_EVERY);
  localparam bit            RTY_EN  = (RTY_EVERY != 0);
  localparam bit            NO_WAIT = (WAIT == 0);

  // FSM and access latches
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          we_q, we_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [TW-1:0] tag_q, tag_d;

  // Registered bus outputs
  logic [DW-1:0] rdat_q, rdat_d;
  logic [TW-1:0] tago_q, tago_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          rty_q, rty_d;

  // Storage
  logic [DW-1:0] mem_q [WORDS];

  // Access currently being terminated (live bus in IDLE, latched copy otherwise)
  logic          a_we;
  logic [aw-1:0] a_adr;
  logic [SW-1:0] a_sel;
  logic [DW-1:0] a_dat;
  logic [TW-1:0] a_tag;
  logic [IW-1:0] a_idx;
  logic          a_oob;
  logic          rty_hit;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          enter_resp;
  logic          unused_adr_lsb;

  // Select the access source for a termination decided this cycle
  always_comb begin
    if (state_q == S_IDLE) begin
      a_we  = WE_I;
      a_adr = ADR_I;
      a_sel = SEL_I;
      a_dat = DAT_I;
      a_tag = TAG_I;
    end else begin
      a_we  = we_q;
      a_adr = adr_q;
      a_sel = sel_q;
      a_dat = wdat_q;
      a_tag = tag_q;
    end
  end

  assign a_idx          = a_adr[5:2];
  assign a_oob          = |a_adr[aw-1:6];
  assign unused_adr_lsb = ^a_adr[1:0];
  assign rty_hit        = RTY_EN && ((acc_q + CW'(1)) == RTY_N);
  assign mem_rdata      = mem_q[a_idx];

  // Byte-lane merge of write data over the current word
  always_comb begin
    mem_wdata = mem_rdata;
    for (int n = 0; n < SW; n++) begin
      if (a_sel[n]) mem_wdata[8*n +: 8] = a_dat[8*n +: 8];
    end
  end

  // Next-state, termination class and output decode
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    acc_d      = acc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    tag_d      = tag_q;
    rdat_d     = rdat_q;
    tago_d     = tago_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rty_d      = 1'b0;
    mem_we     = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CYC_I && STB_I) begin
          we_d   = WE_I;
          adr_d  = ADR_I;
          sel_d  = SEL_I;
          wdat_d = DAT_I;
          tag_d  = TAG_I;
          wcnt_d = WAIT_LD;
          if (NO_WAIT) enter_resp = 1'b1;
          else         state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Master dropping CYC_I abandons the access with no side effects
        if (!CYC_I) begin
          state_d = S_IDLE;
        end else if (wcnt_q == CW'(1)) begin
          enter_resp = 1'b1;
        end else begin
          wcnt_d = wcnt_q - CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_resp) begin
      state_d = S_RESP;
      tago_d  = a_tag;
      if (a_oob) begin
        err_d = 1'b1;
        acc_d = acc_q + CW'(1);
      end else if (rty_hit) begin
        rty_d = 1'b1;
        acc_d = '0;
      end else begin
        ack_d = 1'b1;
        acc_d = acc_q + CW'(1);
        if (a_we) mem_we = 1'b1;
        else      rdat_d = mem_rdata;
      end
    end
  end

  // State, latches and output registers
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      tag_q   <= '0;
      rdat_q  <= '0;
      tago_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      tag_q   <= tag_d;
      rdat_q  <= rdat_d;
      tago_q  <= tago_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
    end
  end

  // Word store; committed on the edge that enters RESP with an ACKed write
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[a_idx] <= mem_wdata;
    end
  end

  assign DAT_O = rdat_q;
  assign TAG_O = tago_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign RTY_O = rty_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: five instances with different
// wait/retry settings share one bus; each vector targets one instance.
module tb_wb_slave_mem;

  localparam int NDUT  = 5;
  localparam int D_W1  = 0;
  localparam int D_W3  = 1;
  localparam int D_W0  = 2;
  localparam int D_RTY = 3;
  localparam int D_W4  = 4;

  localparam logic [2:0] K_ACK = 3'b100;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_RTY = 3'b001;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [7:0]  adr;
  logic [3:0]  sel, tag;
  logic [31:0] dat;

  logic [31:0] dat_o [NDUT];
  logic [3:0]  tag_o [NDUT];
  logic        ack_o [NDUT];
  logic        err_o [NDUT];
  logic        rty_o [NDUT];

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    bit          rst_before;
    int          d;
    logic        we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [3:0]  tag;
    logic [2:0]  kind;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] dat;
    logic [3:0]  tag;
    int          lat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_slave_mem #(.aw(8), .WAIT(1), .RTY_EVERY(0)) u_w1 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(dat), .TAG_I(tag), .DAT_O(dat_o[0]), .ACK_O(ack_o[0]),
    .ERR_O(err_o[0]), .RTY_O(rty_o[0]), .TAG_O(tag_o[0]));
  wb_slave_mem #(.aw(8), .WAIT(3), .RTY_EVERY(0)) u_w3 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(dat), .TAG_I(tag), .DAT_O(dat_o[1]), .ACK_O(ack_o[1]),
    .ERR_O(err_o[1]), .RTY_O(rty_o[1]), .TAG_O(tag_o[1]));
  wb_slave_mem #(.aw(8), .WAIT(0), .RTY_EVERY(0)) u_w0 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(dat), .TAG_I(tag), .DAT_O(dat_o[2]), .ACK_O(ack_o[2]),
    .ERR_O(err_o[2]), .RTY_O(rty_o[2]), .TAG_O(tag_o[2]));
  wb_slave_mem #(.aw(8), .WAIT(2), .RTY_EVERY(3)) u_rty (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(dat), .TAG_I(tag), .DAT_O(dat_o[3]), .ACK_O(ack_o[3]),
    .ERR_O(err_o[3]), .RTY_O(rty_o[3]), .TAG_O(tag_o[3]));
  wb_slave_mem #(.aw(8), .WAIT(4), .RTY_EVERY(0)) u_w4 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(dat), .TAG_I(tag), .DAT_O(dat_o[4]), .ACK_O(ack_o[4]),
    .ERR_O(err_o[4]), .RTY_O(rty_o[4]), .TAG_O(tag_o[4]));

  function automatic int lat_of(input int d);
    case (d)
      D_W1:    return 1;
      D_W3:    return 3;
      D_W0:    return 0;
      D_RTY:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] term(input int d);
    return {ack_o[d], err_o[d], rty_o[d]};
  endfunction

  function automatic vec_t mk(input bit rb, input int d, input logic w, input logic [7:0] a,
                              input logic [3:0] s, input logic [31:0] dt, input logic [3:0] t,
                              input logic [2:0] k, input logic [31:0] ed);
    vec_t v;
    v.rst_before = rb; v.d = d; v.we = w; v.adr = a; v.sel = s; v.dat = dt;
    v.tag = t; v.kind = k; v.exp_dat = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One access: push expectation, drive, wait (bounded) for termination, compare
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    int   lat;
    e.kind = v.kind; e.dat = v.exp_dat; e.tag = v.tag; e.lat = lat_of(v.d);
    sb.push_back(e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; sel = v.sel; dat = v.dat; tag = v.tag;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    lat = 0;
    while (term(v.d) == 3'b000 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (term(v.d) == 3'b000) begin
      n_vec++;
      n_fail++;
      $display("FAIL v%0d timeout: no termination after %0d cycles", id, lat);
    end else begin
      chk($sformatf("v%0d kind", id), 32'(term(v.d)), 32'(e.kind));
      chk($sformatf("v%0d dat", id), dat_o[v.d], e.dat);
      chk($sformatf("v%0d tag", id), 32'(tag_o[v.d]), 32'(e.tag));
      chk($sformatf("v%0d latency", id), 32'(lat), 32'(e.lat));
    end
    @(negedge clk);
    chk($sformatf("v%0d pulse_end", id), 32'(term(v.d)), 32'(0));
    cyc = 1'b0;
  endtask

  task automatic watch_quiet(input string name, input int d, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (term(d) != 3'b000) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat = '0; tag = '0;

    tbl.push_back(mk(0, D_W1, 1, 8'h08, 4'hF, 32'hDEAD_BEEF, 4'h1, K_ACK, 32'h0));
    tbl.push_back(mk(0, D_W1, 0, 8'h08, 4'hF, 32'h0,         4'h2, K_ACK, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, D_W1, 1, 8'h0C, 4'hF, 32'h1122_3344, 4'h3, K_ACK, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, D_W1, 1, 8'h0C, 4'h5, 32'hAABB_CCDD, 4'h4, K_ACK, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, D_W1, 0, 8'h0C, 4'hF, 32'h0,         4'h5, K_ACK, 32'h11BB_33DD));
    tbl.push_back(mk(0, D_W1, 1, 8'h40, 4'hF, 32'hFFFF_FFFF, 4'h6, K_ERR, 32'h11BB_33DD));
    tbl.push_back(mk(0, D_W1, 0, 8'h40, 4'hF, 32'h0,         4'h7, K_ERR, 32'h11BB_33DD));
    tbl.push_back(mk(0, D_W1, 0, 8'h00, 4'hF, 32'h0,         4'h8, K_ACK, 32'h0));
    tbl.push_back(mk(0, D_W1, 0, 8'h0C, 4'h0, 32'h0,         4'h9, K_ACK, 32'h11BB_33DD));
    tbl.push_back(mk(0, D_W3, 1, 8'h10, 4'hF, 32'hCAFE_F00D, 4'hA, K_ACK, 32'h0));
    tbl.push_back(mk(0, D_W3, 0, 8'h10, 4'hF, 32'h0,         4'hB, K_ACK, 32'hCAFE_F00D));
    tbl.push_back(mk(0, D_W0, 0, 8'h0C, 4'hF, 32'h0,         4'hC, K_ACK, 32'h11BB_33DD));
    tbl.push_back(mk(0, D_W0, 0, 8'h7C, 4'hF, 32'h0,         4'hD, K_ERR, 32'h11BB_33DD));
    tbl.push_back(mk(0, D_W0, 1, 8'h3E, 4'h3, 32'h1234_BEEF, 4'hE, K_ACK, 32'h11BB_33DD));
    tbl.push_back(mk(0, D_W0, 0, 8'h3C, 4'hF, 32'h0,         4'hF, K_ACK, 32'h0000_BEEF));
    tbl.push_back(mk(1, D_RTY, 0, 8'h00, 4'hF, 32'h0,         4'h1, K_ACK, 32'h0));
    tbl.push_back(mk(0, D_RTY, 0, 8'h04, 4'hF, 32'h0,         4'h2, K_ACK, 32'h0));
    tbl.push_back(mk(0, D_RTY, 0, 8'h08, 4'hF, 32'h0,         4'h3, K_RTY, 32'h0));
    tbl.push_back(mk(0, D_RTY, 0, 8'h0C, 4'hF, 32'h0,         4'h4, K_ACK, 32'h0));
    tbl.push_back(mk(0, D_RTY, 1, 8'h20, 4'hF, 32'hA5A5_A5A5, 4'h5, K_ACK, 32'h0));
    tbl.push_back(mk(0, D_RTY, 1, 8'h20, 4'hF, 32'hFFFF_FFFF, 4'h6, K_RTY, 32'h0));
    tbl.push_back(mk(0, D_RTY, 0, 8'h20, 4'hF, 32'h0,         4'h7, K_ACK, 32'hA5A5_A5A5));
    tbl.push_back(mk(0, D_W4, 1, 8'h14, 4'hF, 32'h0102_0304, 4'h8, K_ACK, 32'h0));

    // Reset values, during and just after reset
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset dat d%0d", d), dat_o[d], 32'h0);
      chk($sformatf("reset term d%0d", d), 32'(term(d)), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset tag", 32'(tag_o[D_W1]), 32'(0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      apply(tbl[i], i);
    end

    // Abort: CYC_I dropped two cycles after accept of a write on the WAIT=4 slave
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h14; sel = 4'hF; dat = 32'hDEAD_DEAD; tag = 4'h9;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    cyc = 1'b0;
    watch_quiet("abort no_term", D_W4, 8);
    chk("abort tag_held", 32'(tag_o[D_W4]), 32'(4'h8));
    apply(mk(0, D_W4, 0, 8'h14, 4'hF, 32'h0, 4'hA, K_ACK, 32'h0102_0304), 100);

    // Asynchronous reset asserted between edges while the WAIT=4 slave waits
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h04; sel = 4'hF; dat = 32'h0BAD_F00D; tag = 4'hB;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst dat d4", dat_o[D_W4], 32'h0);
    chk("async_rst tag d4", 32'(tag_o[D_W4]), 32'(0));
    chk("async_rst term d4", 32'(term(D_W4)), 32'(0));
    chk("async_rst dat d0", dat_o[D_W1], 32'h0);
    chk("async_rst tag d0", 32'(tag_o[D_W1]), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    cyc = 1'b0;
    watch_quiet("async_rst no_ack", D_W4, 8);
    apply(mk(0, D_W4, 0, 8'h04, 4'hF, 32'h0, 4'hC, K_ACK, 32'h0), 101);
    apply(mk(0, D_W1, 0, 8'h04, 4'hF, 32'h0, 4'hD, K_ACK, 32'h0), 102);
    apply(mk(0, D_W1, 0, 8'h08, 4'hF, 32'h0, 4'hE, K_ACK, 32'h0), 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
